quant_lane_scheduler: RTL

- Shares one bit-serial activation/quantizer unit (32-bit frame, LSB-first, 8-bit clipped output) between NUM_CH accumulator channels.
- Each channel offers a 32-bit accumulator word with a req/ack handshake. The block picks one channel per frame using round-robin arbitration and serialises the granted word onto the quantizer input.
- It captures the quantizer's 8-bit result and emits it with its channel tag through a 2-entry valid/ready output buffer.

---
 rtl/quant_lane_scheduler.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/quant_lane_scheduler.sv
// quant_lane_scheduler
//
// Shares one bit-serial activation/quantizer between NUM_CH accumulator channels.
// Each frame, a round-robin arbiter picks one requesting channel, loads its 32-bit
// word and shifts it LSB-first into the quantizer. The quantizer's 8-bit result for
// a frame is captured CAPTURE_PHASE cycles into the following frame and queued, with
// its channel tag, in a 2-entry output buffer.
//
// Ports:
//   clk        clock
//   reset      asynchronous active-low reset
//   ch_req     per-channel word-available flags
//   ch_data    per-channel words, channel i at [32i+31:32i]
//   ch_ack     one-cycle pulse in the first cycle of the frame carrying that word
//   q_reset    synchronous active-high reset to the quantizer
//   q_data_in  serial bit to the quantizer
//   q_out      quantizer result
//   out_valid / out_ready / out_data / out_ch   result stream with channel tag
//   busy       a frame is in flight or a result is waiting

module quant_lane_scheduler #(
  parameter int unsigned NUM_CH        = 4,
  parameter int unsigned FRAME_LEN     = 32,
  parameter int unsigned CAPTURE_PHASE = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_CH-1:0]     ch_req,
  input  logic [32*NUM_CH-1:0]  ch_data,
  output logic [NUM_CH-1:0]     ch_ack,
  output logic                  q_reset,
  output logic                  q_data_in,
  input  logic [7:0]            q_out,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [7:0]            out_data,
  output logic [2:0]            out_ch,
  output logic                  busy
);

  localparam int unsigned PhW = $clog2(FRAME_LEN);
  localparam logic [PhW-1:0] LastPhase = PhW'(FRAME_LEN - 1);
  localparam logic [PhW-1:0] CapPhase  = PhW'(CAPTURE_PHASE);

  localparam logic [0:0] StSync = 1'b0;
  localparam logic [0:0] StRun  = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [PhW-1:0]    phase_q, phase_d;
  logic [31:0]       shift_q, shift_d;
  logic [NUM_CH-1:0] ack_q, ack_d;
  logic              cur_valid_q, cur_valid_d;
  logic [2:0]        cur_tag_q, cur_tag_d;
  logic              prev_valid_q, prev_valid_d;
  logic [2:0]        prev_tag_q, prev_tag_d;
  logic [2:0]        rr_ptr_q, rr_ptr_d;

  // Two-slot buffer; slot0 is the head and drives the outputs directly.
  logic              slot0_valid_q, slot0_valid_d;
  logic [7:0]        slot0_data_q, slot0_data_d;
  logic [2:0]        slot0_tag_q, slot0_tag_d;
  logic              slot1_valid_q, slot1_valid_d;
  logic [7:0]        slot1_data_q, slot1_data_d;
  logic [2:0]        slot1_tag_q, slot1_tag_d;

  logic [2*NUM_CH-1:0] req_rot;
  logic                grant_found;
  logic [2:0]          grant_ch;
  logic [31:0]         grant_word;
  logic                grant_slot;
  logic                grant;
  logic                pop;
  logic                push;
  logic [2:0]          load;

  // Round-robin search: rotate requests so bit 0 is the channel at rr_ptr.
  always_comb begin
    req_rot     = {ch_req, ch_req} >> rr_ptr_q;
    grant_found = 1'b0;
    grant_ch    = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (!grant_found && req_rot[i]) begin
        grant_found = 1'b1;
        grant_ch    = 3'((32'(rr_ptr_q) + i) % NUM_CH);
      end
    end
  end

  always_comb begin
    grant_word = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (3'(i) == grant_ch) begin
        grant_word = ch_data[32*i +: 32];
      end
    end
  end

  assign pop        = slot0_valid_q & out_ready;
  assign push       = (state_q == StRun) && (phase_q == CapPhase) && prev_valid_q;
  assign grant_slot = (state_q == StSync) || (phase_q == LastPhase);

  // Results already owed: post-pop occupancy plus every valid frame still in flight.
  assign load  = 3'(slot0_valid_q) + 3'(slot1_valid_q) - 3'(pop)
               + 3'(cur_valid_q) + 3'(prev_valid_q);
  assign grant = grant_slot && grant_found && (load < 3'd2);

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    shift_d      = shift_q >> 1;
    ack_d        = '0;
    cur_valid_d  = cur_valid_q;
    cur_tag_d    = cur_tag_q;
    prev_valid_d = prev_valid_q;
    prev_tag_d   = prev_tag_q;
    rr_ptr_d     = rr_ptr_q;

    if (state_q == StSync) begin
      state_d = StRun;
      phase_d = '0;
    end else begin
      phase_d = (phase_q == LastPhase) ? '0 : phase_q + PhW'(1);
    end

    if (push) begin
      prev_valid_d = 1'b0;
    end

    if (grant_slot) begin
      prev_valid_d = cur_valid_q;
      prev_tag_d   = cur_tag_q;
      cur_valid_d  = grant;
      cur_tag_d    = grant ? grant_ch : 3'd0;
      shift_d      = grant ? grant_word : 32'd0;
      if (grant) begin
        rr_ptr_d = 3'((32'(grant_ch) + 1) % NUM_CH);
        for (int unsigned i = 0; i < NUM_CH; i++) begin
          ack_d[i] = (3'(i) == grant_ch);
        end
      end
    end
  end

  // Pop shifts slot1 forward first, so a same-cycle push lands in the first free slot.
  always_comb begin
    slot0_valid_d = slot0_valid_q;
    slot0_data_d  = slot0_data_q;
    slot0_tag_d   = slot0_tag_q;
    slot1_valid_d = slot1_valid_q;
    slot1_data_d  = slot1_data_q;
    slot1_tag_d   = slot1_tag_q;
    if (pop) begin
      slot0_valid_d = slot1_valid_q;
      slot0_data_d  = slot1_data_q;
      slot0_tag_d   = slot1_tag_q;
      slot1_valid_d = 1'b0;
    end
    if (push) begin
      if (!slot0_valid_d) begin
        slot0_valid_d = 1'b1;
        slot0_data_d  = q_out;
        slot0_tag_d   = prev_tag_q;
      end else begin
        slot1_valid_d = 1'b1;
        slot1_data_d  = q_out;
        slot1_tag_d   = prev_tag_q;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= StSync;
      phase_q       <= '0;
      shift_q       <= '0;
      ack_q         <= '0;
      cur_valid_q   <= 1'b0;
      cur_tag_q     <= '0;
      prev_valid_q  <= 1'b0;
      prev_tag_q    <= '0;
      rr_ptr_q      <= '0;
      slot0_valid_q <= 1'b0;
      slot0_data_q  <= '0;
      slot0_tag_q   <= '0;
      slot1_valid_q <= 1'b0;
      slot1_data_q  <= '0;
      slot1_tag_q   <= '0;
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      shift_q       <= shift_d;
      ack_q         <= ack_d;
      cur_valid_q   <= cur_valid_d;
      cur_tag_q     <= cur_tag_d;
      prev_valid_q  <= prev_valid_d;
      prev_tag_q    <= prev_tag_d;
      rr_ptr_q      <= rr_ptr_d;
      slot0_valid_q <= slot0_valid_d;
      slot0_data_q  <= slot0_data_d;
      slot0_tag_q   <= slot0_tag_d;
      slot1_valid_q <= slot1_valid_d;
      slot1_data_q  <= slot1_data_d;
      slot1_tag_q   <= slot1_tag_d;
    end
  end

  // The credit rule makes a push into a full, non-popping buffer impossible.
  always_ff @(posedge clk) begin
    if (reset) begin
      assert (!(push && slot1_valid_q && !pop));
    end
  end

  assign ch_ack    = ack_q;
  assign q_reset   = (state_q == StSync);
  assign q_data_in = shift_q[0];
  assign out_valid = slot0_valid_q;
  assign out_data  = slot0_data_q;
  assign out_ch    = slot0_tag_q;
  assign busy      = cur_valid_q | prev_valid_q | slot0_valid_q;

endmodule
